// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair, with start/busy/done handshake.
module mips_muldiv_unit #(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [LENGTH-1:0] i_a,
  input  logic [LENGTH-1:0] i_b,
  input  logic              i_flush,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_by_zero,
  output logic [LENGTH-1:0] o_hi,
  output logic [LENGTH-1:0] o_lo
);
  localparam int CW = $clog2(LENGTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, zero, ab_sign, r_sign, sgn_op, b_zero;
  logic [LENGTH-1:0] mcand, mag_a, mag_b, quo_fix, rem_fix;
  logic [2*LENGTH-1:0] acc, prod_fix;
  logic [LENGTH:0] rem, add_sum, rem_sh;
  logic [LENGTH+1:0] trial;
  always_comb begin
    sgn_op = ~i_op[0];
    b_zero = i_op[1] && (i_b == '0);
    mag_a = (sgn_op && i_a[LENGTH-1]) ? -i_a : i_a;
    mag_b = (sgn_op && i_b[LENGTH-1]) ? -i_b : i_b;
    add_sum = {1'b0, acc[2*LENGTH-1:LENGTH]} + {1'b0, mcand & {LENGTH{acc[0]}}};
    rem_sh = {rem[LENGTH-1:0], acc[LENGTH-1]};
    trial = {1'b0, rem_sh} - {2'b0, mcand};
    prod_fix = ab_sign ? -acc : acc;
    quo_fix = ab_sign ? -acc[LENGTH-1:0] : acc[LENGTH-1:0];
    rem_fix = r_sign ? -rem[LENGTH-1:0] : rem[LENGTH-1:0];
  end
  // acc holds {partial product, multiplier} for multiply and the dividend/quotient shifter for divide
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      zero <= 1'b0;
      ab_sign <= 1'b0;
      r_sign <= 1'b0;
      mcand <= '0;
      acc <= '0;
      rem <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_hi <= '0;
      o_lo <= '0;
    end else begin
      o_done <= 1'b0;
      o_div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_flush) begin
            is_div <= i_op[1];
            zero <= b_zero;
            ab_sign <= sgn_op & (i_a[LENGTH-1] ^ i_b[LENGTH-1]);
            r_sign <= sgn_op & i_a[LENGTH-1];
            mcand <= i_op[1] ? mag_b : mag_a;
            acc <= {{LENGTH{1'b0}}, i_op[1] ? mag_a : mag_b};
            rem <= '0;
            cnt <= '0;
            o_busy <= 1'b1;
            state <= b_zero ? FIX : CALC;
          end else if (!i_start) begin
            if (i_mthi) o_hi <= i_a;
            if (i_mtlo) o_lo <= i_a;
          end
        end
        CALC: begin
          if (i_flush) begin
            o_busy <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              rem <= trial[LENGTH+1] ? rem_sh : trial[LENGTH:0];
              acc[LENGTH-1:0] <= {acc[LENGTH-2:0], ~trial[LENGTH+1]};
            end else begin
              acc <= {add_sum, acc[LENGTH-1:1]};
            end
            if (cnt == CW'(LENGTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          o_busy <= 1'b0;
          state <= IDLE;
          if (!i_flush) begin
            o_done <= 1'b1;
            o_div_by_zero <= zero;
            if (!zero) begin
              o_hi <= is_div ? rem_fix : prod_fix[2*LENGTH-1:LENGTH];
              o_lo <= is_div ? quo_fix : prod_fix[LENGTH-1:0];
            end
          end
        end
        default: begin
          o_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: arithmetic/timing reference model compared every cycle, plus hand-computed directed vectors.
module tb_mips_muldiv_unit;
  localparam int L = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'd0;
  logic [L-1:0] a = '0, b = '0;
  logic o_busy, o_done, o_dbz;
  logic [L-1:0] o_hi, o_lo;
  logic s_start = 1'b0;
  logic [1:0] s_op = 2'd0;
  logic [7:0] s_a = '0, s_b = '0;
  logic s_busy, s_done, s_dbz;
  logic [7:0] s_hi, s_lo;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.LENGTH(L)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .i_mthi(mthi), .i_mtlo(mtlo), .o_busy(o_busy), .o_done(o_done),
    .o_div_by_zero(o_dbz), .o_hi(o_hi), .o_lo(o_lo)
  );

  mips_muldiv_unit #(.LENGTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_op(s_op), .i_a(s_a), .i_b(s_b),
    .i_flush(1'b0), .i_mthi(1'b0), .i_mtlo(1'b0), .o_busy(s_busy), .o_done(s_done),
    .o_div_by_zero(s_dbz), .o_hi(s_hi), .o_lo(s_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = {32'b0, x} * {32'b0, y};
      2'd2: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      default: p = {x % y, x / y};
    endcase
    return p;
  endfunction

  // reference model: m_left counts the busy cycles still to go before the done edge
  int m_left = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, m_pz = 1'b0;
  logic [L-1:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      m_dbz = 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left = 0;
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_dbz = m_pz;
            if (!m_pz) {m_hi, m_lo} = m_res;
          end
        end
      end else if (start && !flush) begin
        m_pz = op[1] && (b == 0);
        if (!m_pz) m_res = ref_result(op, a, b);
        m_busy = 1'b1;
        m_left = m_pz ? 1 : L + 1;
      end else if (!start) begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(o_busy), 64'(m_busy));
    check("done", 64'(o_done), 64'(m_done));
    check("div_by_zero", 64'(o_dbz), 64'(m_dbz));
    check("hi", 64'(o_hi), 64'(m_hi));
    check("lo", 64'(o_lo), 64'(m_lo));
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int lat,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input string nm);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (o_done) break;
    end
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " hi"}, 64'(o_hi), 64'(eh));
    check({nm, " lo"}, 64'(o_lo), 64'(el));
    check({nm, " dbz"}, 64'(o_dbz), 64'(edz));
  endtask

  initial begin
    int n, nd;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(o_hi), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    do_op(2'd0, 32'hFFFFFFFF, 32'd5, 34, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, "mult");
    do_op(2'd1, 32'hFFFFFFFF, 32'd5, 34, 32'h00000004, 32'hFFFFFFFB, 1'b0, "multu");
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div -7/2");
    do_op(2'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, "divu 100/7");
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0, 32'h80000000, 1'b0, "div min/-1");
    do_op(2'd2, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 1'b0, "div 7/-2");
    do_op(2'd0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'd0, 1'b0, "mult min*min");
    @(negedge clk);
    a = 32'h1234; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; a = 32'h5678; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mthi", 64'(o_hi), 64'h1234);
    check("mtlo", 64'(o_lo), 64'h5678);
    do_op(2'd3, 32'd9, 32'd0, 2, 32'h1234, 32'h5678, 1'b1, "divu by zero");
    @(negedge clk);
    op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_done) nd++;
    end
    check("flush no done", 64'(nd), 64'd0);
    check("flush hi", 64'(o_hi), 64'h1234);
    check("flush lo", 64'(o_lo), 64'h5678);
    @(negedge clk);
    op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op = 2'd3; a = 32'hDEAD; b = 32'd0; start = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    n = 0;
    while (!o_done && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("busy-ignore done", 64'(o_done), 64'd1);
    check("busy-ignore hi", 64'(o_hi), 64'd0);
    check("busy-ignore lo", 64'(o_lo), 64'd42);
    check("busy-ignore dbz", 64'(o_dbz), 64'd0);
    @(negedge clk);
    op = 2'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async busy", 64'(o_busy), 64'd0);
    check("async done", 64'(o_done), 64'd0);
    check("async hi", 64'(o_hi), 64'd0);
    check("async lo", 64'(o_lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_op = 2'd0; s_a = 8'hFF; s_b = 8'd5; s_start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    s_start = 1'b0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      #1;
      if (s_done) break;
    end
    check("len8 latency", 64'(n), 64'd10);
    check("len8 hi", 64'(s_hi), 64'hFF);
    check("len8 lo", 64'(s_lo), 64'hFB);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
